// File: rtl/bram_pkg.sv
// bram_pkg: shared definitions for the parametrised dual-port block RAM.
//   - WRITE_MODE encodings (what dout shows on a write cycle)
//   - controller state enum (post-reset clear vs. normal operation)
//   - be_w(): number of byte lanes for a given data width
package bram_pkg;

  localparam int WM_WRITE_FIRST = 0;  // dout = merged new word
  localparam int WM_READ_FIRST  = 1;  // dout = word before the write
  localparam int WM_NO_CHANGE   = 2;  // dout untouched, no valid strobe

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// bram_rd_pipe: per-port read-data output pipeline.
//   RD_LAT register stages carry (valid, data). A stage only loads data when
//   its incoming valid is set, so the output word holds between strobes.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   vld_i, data_i  stage-0 result (combinational, from the array port)
//   vld_o, data_o  registered result, RD_LAT clocks later
module bram_rd_pipe #(
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic [RD_LAT-1:0]             vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0][DATA_W-1:0] dat_pipe_q, dat_pipe_d;

  // Stage s is fed by stage s-1; stage 0 is fed by the inputs.
  always_comb begin
    vld_pipe_d    = '0;
    dat_pipe_d    = '0;
    vld_pipe_d[0] = vld_i;
    dat_pipe_d[0] = data_i;
    for (int s = 1; s < RD_LAT; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      dat_pipe_d[s] = dat_pipe_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      for (int s = 0; s < RD_LAT; s++)
        if (vld_pipe_d[s]) dat_pipe_q[s] <= dat_pipe_d[s];
    end
  end

  assign vld_o  = vld_pipe_q[RD_LAT-1];
  assign data_o = dat_pipe_q[RD_LAT-1];

endmodule

// File: rtl/bram_dpm_param.sv
// bram_dpm_param: parametrised true dual-port block RAM with byte enables,
// selectable write mode, 1/2-cycle read latency, post-reset zero fill and
// defined same-address collision resolution.
// Port A faces the SD data engine, port B the host/DMA side.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   en_x, wr_x, be_x, addr_x   access enable, write, byte enables, address
//   din_x / dout_x, vld_x      write data / read data and its valid strobe
//   init_busy / init_done      zero-fill running / RAM ready
//   collision, coll_cnt        registered collision pulse, saturating count
// Optional: define BRAM_COLLISION_DET_EN to build the collision detector;
// otherwise collision and coll_cnt are tied to zero.
module bram_dpm_param
  import bram_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 11,
  parameter int RD_LAT         = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_a,
  input  logic                    wr_a,
  input  logic [be_w(DATA_W)-1:0] be_a,
  input  logic [ADDR_W-1:0]       addr_a,
  input  logic [DATA_W-1:0]       din_a,
  output logic [DATA_W-1:0]       dout_a,
  output logic                    vld_a,
  input  logic                    en_b,
  input  logic                    wr_b,
  input  logic [be_w(DATA_W)-1:0] be_b,
  input  logic [ADDR_W-1:0]       addr_b,
  input  logic [DATA_W-1:0]       din_b,
  output logic [DATA_W-1:0]       dout_b,
  output logic                    vld_b,
  output logic                    init_busy,
  output logic                    init_done,
  output logic                    collision,
  output logic [7:0]              coll_cnt
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              init_done_q, init_done_d;
  logic              ready;

  logic              rd_a, we_a, rd_b, we_b, same_addr, ww_hit;
  logic [DATA_W-1:0] old_a, old_b, wr_word_a, wr_word_b;
  logic              s0_vld_a, s0_vld_b;
  logic [DATA_W-1:0] s0_dat_a, s0_dat_b;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                              input logic [DATA_W-1:0] din,
                                              input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] w;
    w = base;
    for (int i = 0; i < BE_W; i++)
      if (be[i]) w[8*i +: 8] = din[8*i +: 8];
    return w;
  endfunction

  // Clear sequencer: one zero word per clock, then READY until next reset.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (&clr_addr_q) state_d = ST_READY;
    end
    init_done_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      init_done_q <= init_done_d;
    end
  end

  assign ready     = (state_q == ST_READY);
  assign init_busy = (state_q == ST_CLEAR);
  assign init_done = init_done_q;

  // Access decode and write-data resolution. On a same-address double
  // write, port B's merged word gets port A's lanes laid on top, so A wins
  // shared lanes and each port keeps its exclusive lanes. Both ports then
  // write the identical resolved word.
  always_comb begin
    rd_a      = ready & en_a & ~wr_a;
    we_a      = ready & en_a & wr_a;
    rd_b      = ready & en_b & ~wr_b;
    we_b      = ready & en_b & wr_b;
    same_addr = (addr_a == addr_b);
    ww_hit    = we_a & we_b & same_addr;
    old_a     = mem[addr_a];
    old_b     = mem[addr_b];
    wr_word_b = merge(old_b, din_b, be_b);
    if (ww_hit) wr_word_b = merge(wr_word_b, din_a, be_a);
    wr_word_a = ww_hit ? wr_word_b : merge(old_a, din_a, be_a);
  end

  // Array is not reset; writes are held off while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!ready) begin
        mem[clr_addr_q] <= '0;
      end else begin
        if (we_a) mem[addr_a] <= wr_word_a;
        if (we_b) mem[addr_b] <= wr_word_b;
      end
    end
  end

  // Reads see the pre-write array contents, which gives read/write
  // collisions their old-data result for free.
  always_comb begin
    s0_vld_a = rd_a | (we_a & (WRITE_MODE != WM_NO_CHANGE));
    s0_vld_b = rd_b | (we_b & (WRITE_MODE != WM_NO_CHANGE));
    s0_dat_a = (we_a && WRITE_MODE == WM_WRITE_FIRST) ? wr_word_a : old_a;
    s0_dat_b = (we_b && WRITE_MODE == WM_WRITE_FIRST) ? wr_word_b : old_b;
  end

  bram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_a (
    .clk(clk), .rst_n(rst_n), .vld_i(s0_vld_a), .data_i(s0_dat_a),
    .vld_o(vld_a), .data_o(dout_a)
  );

  bram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_b (
    .clk(clk), .rst_n(rst_n), .vld_i(s0_vld_b), .data_i(s0_dat_b),
    .vld_o(vld_b), .data_o(dout_b)
  );

`ifdef BRAM_COLLISION_DET_EN
  logic       coll_d, collision_q;
  logic [7:0] coll_cnt_q, coll_cnt_d;

  always_comb begin
    coll_d     = ready & en_a & en_b & same_addr & (wr_a | wr_b);
    coll_cnt_d = coll_cnt_q;
    if (coll_d && coll_cnt_q != 8'hFF) coll_cnt_d = coll_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
      coll_cnt_q  <= '0;
    end else begin
      collision_q <= coll_d;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

  assign collision = collision_q;
  assign coll_cnt  = coll_cnt_q;
`else
  assign collision = 1'b0;
  assign coll_cnt  = '0;
`endif

endmodule

// File: doc/bram_dpm_param.md
Name: bram_dpm_param

Overview:
- Parametrised true dual-port block RAM; successor to the fixed 2048x64 dual-port RAM used by the SD-card read path.
- Adds the following over the fixed-size part:
  - configurable width and depth
  - per-byte write enables
  - selectable write mode
  - 1- or 2-cycle read latency with per-port valid strobes
  - a post-reset clear sequencer
  - defined cross-port collision resolution
- Sits between the SD data engine (port A) and the host/DMA side (port B).

Parameters:
- DATA_W, 64, data width in bits; must be a multiple of 8.
- ADDR_W, 11, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in clocks; legal values 1 or 2.
- WRITE_MODE, 0, dout on write: 0 = write-first, 1 = read-first, 2 = no-change.
- CLEAR_ON_RESET, 1, when 1, zero-fill all words after reset.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_a  in  1  port A access enable.
- wr_a  in  1  port A write (when en_a=1).
- be_a  in  DATA_W/8  port A byte write enables.
- addr_a  in  ADDR_W  port A address.
- din_a  in  DATA_W  port A write data.
- dout_a  out  DATA_W  port A read data.
- vld_a  out  1  port A dout valid strobe.
- en_b, wr_b, be_b, addr_b, din_b, dout_b, vld_b: same definitions as port A, for port B.
- init_busy  out  1  clear sequence in progress; user accesses are ignored while high.
- init_done  out  1  RAM ready; stays high until next reset.
- collision  out  1  registered same-address collision pulse.
- coll_cnt  out  8  saturating collision count.

Behaviour:
- Reset values (rst_n=0):
  - dout_a = dout_b = 0, vld_a = vld_b = 0, collision = 0, coll_cnt = 0, init_done = 0.
  - init_busy = CLEAR_ON_RESET.
  - Memory contents are not reset.
- FSM states: CLEAR, READY.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - CLEAR: internal counter clr_addr starts at 0. One zero word is written per clock through port A's array port, DEPTH clocks total. After the write to DEPTH-1, go to READY; init_busy falls and init_done rises on the same edge.
  - Reset asserted mid-clear restarts the clear from address 0.
- While init_busy=1: en_a and en_b are ignored, no writes land, vld stays 0.
- Read (en=1, wr=0): the word at addr appears on dout exactly RD_LAT clocks later, with vld=1 for one clock. Back-to-back reads give one result per clock.
- With RD_LAT=2, an extra output register stage is added; vld is delayed identically.
- dout holds its last value when vld=0.
- Write (en=1, wr=1): only byte lanes with be[i]=1 are updated. An all-zero be is a no-op write.
- dout/vld on a write, by WRITE_MODE:
  - 0: merged new word, vld=1.
  - 1: old word, vld=1.
  - 2: dout unchanged, vld=0.
- Collision: en_a & en_b & (addr_a==addr_b) & (wr_a | wr_b), in READY only.
  - Write/write: for lanes enabled on both ports, port A data wins; lanes enabled on only one port take that port's data.
  - Read/write: the reading port returns the pre-write (old) word.
  - collision pulses 1 clock after the colliding cycle; coll_cnt increments and saturates at 255.
- Read/read to the same address is not a collision.
- Addresses are always in range (full ADDR_W decode); there is no wrap-around case.

Optional Feature:
- Macro: BRAM_COLLISION_DET_EN.
- Defined: collision and coll_cnt behave as above.
- Undefined: collision = 0 and coll_cnt = 0 constantly and the comparator logic is removed. Write/write and read/write resolution rules still apply.

Decomposition:
- Package bram_pkg holds:
  - WRITE_MODE constants (WM_WRITE_FIRST, WM_READ_FIRST, WM_NO_CHANGE)
  - FSM state enum (ST_CLEAR, ST_READY)
  - the function computing BE_W = DATA_W/8.
- Sub-module bram_rd_pipe: per-port dout/vld pipeline (RD_LAT 1/2, hold on idle). Instantiated twice.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_W=4:
  - init_busy high for exactly 16 clocks after rst_n rises, then init_done=1.
  - Read of addr 5 returns 0 with vld one clock later.
- Write addr 3 = 64'h1122334455667788 with be=8'hFF, then write be=8'h01 with din=64'hFF, then read addr 3 → 64'h11223344556677FF.
- RD_LAT=2: reads to addrs 0,1,2 on consecutive clocks → three vld pulses starting 2 clocks after the first request, in order.
- Same clock, addr 7:
  - port A writes 64'hAAAA, port B writes 64'hBBBB, both be=all ones → later read returns 64'hAAAA.
  - collision=1 the next clock; coll_cnt=1.
- Port A writes 64'h5 to addr 9 (old value 64'h2) while port B reads addr 9 → dout_b = 64'h2. A later read of addr 9 returns 64'h5.
- rst_n asserted at clr_addr=8, then released → clear restarts from 0; init_busy stays high for a full DEPTH clocks.
